// File: rtl/foc_cmd_decoder.sv
// Command decoder behind the SPI slave: takes opcode/payload frames, holds the motor config registers
// and sequences one FOC run (start pulse, run-length countdown, done or abort).
//
// state | meaning
// IDLE  | waiting for a frame, ready=1
// START | one-cycle foc_start pulse, refs already latched
// RUN   | run_active=1, counter counting down to the end of the run
module foc_cmd_decoder #(
  parameter logic [7:0] OP_CFG  = 8'h01,
  parameter logic [7:0] OP_FOC  = 8'h02,
  parameter logic [7:0] OP_STOP = 8'h03,
  parameter int         CNT_W   = 32
) (
  input  logic        clk_sys,
  input  logic        rstb,
  input  logic [7:0]  opcode,
  input  logic [79:0] data_packed,
  input  logic        valid,
  input  logic        foc_done,
  output logic [15:0] cfg_kp,
  output logic [15:0] cfg_ki,
  output logic [15:0] cfg_period,
  output logic [15:0] cfg_dead,
  output logic [15:0] cfg_vlim,
  output logic        cfg_valid,
  output logic [15:0] iq_ref,
  output logic [15:0] id_ref,
  output logic [15:0] theta0,
  output logic        foc_start,
  output logic        foc_abort,
  output logic        run_active,
  output logic        ready,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t             state, state_nxt;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt;
  logic               fv;
  logic               is_cfg, is_foc, is_stop, is_known;
  logic [CNT_W-1:0]   len;
  logic               foc_ok;
  logic               stop_run;

  assign fv       = valid & ~valid_q;
  assign is_cfg   = (opcode == OP_CFG);
  assign is_foc   = (opcode == OP_FOC);
  assign is_stop  = (opcode == OP_STOP);
  assign is_known = is_cfg | is_foc | is_stop;
  assign len      = data_packed[CNT_W-1:0];
  assign foc_ok   = is_foc & cfg_valid & (len != '0);
  assign stop_run = (state == RUN) & fv & is_stop;

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fv && foc_ok) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (stop_run || foc_done || cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from the state register only, so no input reaches these outputs combinationally.
  always_comb begin
    foc_start  = (state == START);
    run_active = (state == RUN);
    ready      = (state == IDLE);
  end

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      valid_q    <= 1'b0;
      foc_abort  <= 1'b0;
      cnt        <= '0;
      cfg_kp     <= '0;
      cfg_ki     <= '0;
      cfg_period <= '0;
      cfg_dead   <= '0;
      cfg_vlim   <= '0;
      cfg_valid  <= 1'b0;
      iq_ref     <= '0;
      id_ref     <= '0;
      theta0     <= '0;
      err        <= 2'd0;
    end else begin
      valid_q   <= valid;
      foc_abort <= stop_run;
      if (state == RUN && cnt != '0) cnt <= cnt - CNT_W'(1);
      if (fv) begin
        if (!is_known) begin
          err <= 2'd1;
        end else if (state == IDLE) begin
          if (is_cfg) begin
            cfg_kp     <= data_packed[79:64];
            cfg_ki     <= data_packed[63:48];
            cfg_period <= data_packed[47:32];
            cfg_dead   <= data_packed[31:16];
            cfg_vlim   <= data_packed[15:0];
            cfg_valid  <= 1'b1;
            err        <= 2'd0;
          end else if (is_foc) begin
            if (foc_ok) begin
              iq_ref <= data_packed[79:64];
              id_ref <= data_packed[63:48];
              theta0 <= data_packed[47:32];
              cnt    <= len;
              err    <= 2'd0;
            end else begin
              err <= 2'd2;
            end
          end
        end else if (is_cfg || is_foc) begin
          // A live run is never disturbed; the frame is lost and flagged.
          err <= 2'd3;
        end
      end
    end
  end

endmodule
